// File: rtl/mont_arb_pkg.sv
// Shared types for the Montgomery multiplier arbiter: FSM states, the
// issue tag carried alongside each product, and the round-robin picker.
package mont_arb_pkg;

  // Upper bound on requester count supported by the picker and tag id field.
  localparam int MAX_REQ   = 32;
  localparam int MAX_IDX_W = 5;
  localparam int ID_MAX_W  = 5;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // One entry of the result-routing pipe: issue happened, and for whom.
  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  // First set bit of valid searching ptr, ptr+1, ... wrapping at n.
  // Returns a one-hot (or zero) vector; bits at or above n are always zero.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [MAX_IDX_W-1:0] ptr,
                                                 input int unsigned n);
    logic [MAX_REQ-1:0] oh;
    logic               found;
    int unsigned        idx;
    oh    = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n && !found) begin
        idx = 32'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[MAX_IDX_W-1:0]]) begin
          oh[idx[MAX_IDX_W-1:0]] = 1'b1;
          found                  = 1'b1;
        end
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/mont_mul_arbiter_rr.sv
// Round-robin picker for the multiplier arbiter: combinational one-hot grant
// plus the rotating priority pointer, which advances past each winner.
module mont_arb_rr
  import mont_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            hs_o
);

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MAX_REQ-1:0] pick;
  logic               pick_unused;

  assign pick = rr_pick(MAX_REQ'(req_valid_i), MAX_IDX_W'(rr_ptr_q), 32'(NREQ));
  // Picker bits at or above NREQ are structurally zero.
  assign pick_unused = ^pick;

  // Grant only when the FSM allows issue; any grant is a handshake since it
  // is derived from req_valid.
  always_comb begin
    grant_o = en_i ? pick[NREQ-1:0] : '0;
    hs_o    = |grant_o;
  end

  // One-hot to index for the tag pipe and pointer update.
  always_comb begin
    gnt_id_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_o[i]) gnt_id_o = IDW'(i);
    end
  end

  // Next pointer: one past the winner, wrapping at NREQ.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs_o) rr_ptr_d = (gnt_id_o == IDW'(NREQ - 1)) ? '0 : gnt_id_o + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Shares one pipelined Montgomery multiplier among NREQ requesters.
// Round-robin issue, one product per cycle, results routed back by a tag
// pipe matching the multiplier latency. Owns the M / M_inv registers and
// drains in-flight work before a modulus change takes effect.
// Optional build macro: MONT_ARB_PERF_EN adds per-requester issue counters
// and a stall counter.
module mont_mul_arbiter
  import mont_arb_pkg::*;
#(
  parameter int W      = 32,
  parameter int M_BITS = 8,
  parameter int NREQ   = 4,
  parameter int LAT    = W / M_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*W-1:0]   req_a_i,
  input  logic [NREQ*W-1:0]   req_b_i,
  output logic [NREQ-1:0]     rsp_valid_o,
  output logic [W-1:0]        rsp_s_o,
  input  logic                cfg_we_i,
  input  logic [W-1:0]        cfg_m_i,
  input  logic [M_BITS-1:0]   cfg_minv_i,
  output logic [W-1:0]        mul_a_o,
  output logic [W-1:0]        mul_b_o,
  output logic [W-1:0]        mul_m_o,
  output logic [M_BITS-1:0]   mul_minv_o,
  input  logic [W-1:0]        mul_s_i,
  output logic                idle_o
`ifdef MONT_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]  perf_issue_cnt_o,
  output logic [31:0]         perf_stall_cnt_o
`endif
);

  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LAT + 1);

  arb_state_e        state_q, state_d;
  logic [W-1:0]      m_q, m_d, pm_q, pm_d;
  logic [M_BITS-1:0] minv_q, minv_d, pminv_q, pminv_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              gnt_en;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gnt_id;
  logic              hs;
  tag_t              tag_q [LAT];
  logic              rsp_any;

  mont_arb_rr #(.NREQ(NREQ)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .en_i        (gnt_en),
    .grant_o     (grant),
    .gnt_id_o    (gnt_id),
    .hs_o        (hs)
  );

  // Config FSM: decides when grants are allowed and when M / M_inv change.
  // A modulus change with work in flight parks in DRAIN so old products
  // complete under the old modulus.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    minv_d  = minv_q;
    pm_d    = pm_q;
    pminv_d = pminv_q;
    gnt_en  = 1'b0;
    case (state_q)
      UNCFG: begin
        if (cfg_we_i) begin
          m_d     = cfg_m_i;
          minv_d  = cfg_minv_i;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cfg_we_i) begin
          if (inflight_q == '0) begin
            m_d    = cfg_m_i;
            minv_d = cfg_minv_i;
          end else begin
            pm_d    = cfg_m_i;
            pminv_d = cfg_minv_i;
            state_d = DRAIN;
          end
        end else begin
          gnt_en = 1'b1;
        end
      end
      DRAIN: begin
        if (cfg_we_i) begin
          pm_d    = cfg_m_i;
          pminv_d = cfg_minv_i;
        end
        if (inflight_q == '0) begin
          // A write landing on the copy cycle is the newest value; take it.
          m_d     = cfg_we_i ? cfg_m_i    : pm_q;
          minv_d  = cfg_we_i ? cfg_minv_i : pminv_q;
          state_d = RUN;
        end
      end
      default: state_d = UNCFG;
    endcase
    if (rst) gnt_en = 1'b0;
  end

  // FSM, config and pending registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCFG;
      m_q     <= '0;
      minv_q  <= '0;
      pm_q    <= '0;
      pminv_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      minv_q  <= minv_d;
      pm_q    <= pm_d;
      pminv_q <= pminv_d;
    end
  end

  // Operand mux: granted operands in the handshake cycle, zero bubble otherwise.
  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mul_a_o = req_a_i[i*W +: W];
        mul_b_o = req_b_i[i*W +: W];
      end
    end
  end

  assign req_ready_o = grant;
  assign mul_m_o     = m_q;
  assign mul_minv_o  = minv_q;
  assign rsp_s_o     = mul_s_i;

  // Tag pipe: shadows the multiplier so the last entry lines up with mul_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: hs, id: ID_MAX_W'(gnt_id)};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rsp_any = tag_q[LAT-1].vld & ~rst;

  // Result strobe decoded from the emerging tag.
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_o[i] = rsp_any && (tag_q[LAT-1].id == ID_MAX_W'(i));
    end
  end

  // In-flight count; a simultaneous issue and retire cancel out.
  always_comb inflight_d = inflight_q + CNT_W'(hs) - CNT_W'(rsp_any);

  // In-flight count register.
  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  // Idle once the only work left (if any) is the result emerging this cycle.
  assign idle_o = (state_q == RUN) && !hs && (inflight_q == CNT_W'(rsp_any));

`ifdef MONT_ARB_PERF_EN
  logic [NREQ-1:0][31:0] issue_cnt_q;
  logic [31:0]           stall_cnt_q;

  // Per-requester issue counts and stalled-request cycles; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) issue_cnt_q[i] <= issue_cnt_q[i] + 32'd1;
      end
      if (|req_valid_i && !hs) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_issue_cnt_o = issue_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench for mont_mul_arbiter. A behavioural bit-serial Montgomery
// multiplier with a 4-cycle pipe stands in for mont_mul.
module tb_mont_mul_arbiter;

  localparam int W = 32, MB = 8, NREQ = 4, LAT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      rsp_s, cfg_m, mul_a, mul_b, mul_m, mul_s;
  logic [MB-1:0]     cfg_minv, mul_minv;
  logic              cfg_we, idle;
`ifdef MONT_ARB_PERF_EN
  logic [NREQ*32-1:0] perf_issue_cnt;
  logic [31:0]        perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mont_mul_arbiter #(.W(W), .M_BITS(MB), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_s_o     (rsp_s),
    .cfg_we_i    (cfg_we),
    .cfg_m_i     (cfg_m),
    .cfg_minv_i  (cfg_minv),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_m_o     (mul_m),
    .mul_minv_o  (mul_minv),
    .mul_s_i     (mul_s),
    .idle_o      (idle)
`ifdef MONT_ARB_PERF_EN
    ,
    .perf_issue_cnt_o (perf_issue_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  // a*b*2^-32 mod m, bit-serial.
  function automatic logic [31:0] redc(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] m);
    logic [63:0] t;
    t = '0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) t = t + {32'd0, b};
      if (t[0]) t = t + {32'd0, m};
      t = t >> 1;
    end
    if (t >= {32'd0, m}) t = t - {32'd0, m};
    return t[31:0];
  endfunction

  logic [31:0] s_pipe [LAT];
  always @(posedge clk) begin
    s_pipe[0] <= redc(mul_a, mul_b, mul_m);
    for (int i = 1; i < LAT; i++) s_pipe[i] <= s_pipe[i-1];
  end
  assign mul_s = s_pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_cfg(input logic [31:0] m);
    cfg_we = 1'b1; cfg_m = m; cfg_minv = 8'hFF;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; cfg_we = 1'b0; cfg_m = '0; cfg_minv = '0;
    req_a = '0; req_b = '0;
    tick(); tick();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp got %b want 0000", rsp_valid); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL reset_idle got %b want 0", idle); end
    total++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin bad++; $display("FAIL reset_mul_ab got %0d/%0d want 0/0", mul_a, mul_b); end
    total++; if (mul_m !== 32'd0 || mul_minv !== 8'd0) begin bad++; $display("FAIL reset_cfg got %0d/%h want 0/00", mul_m, mul_minv); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_uncfg();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd1353, 32'd5 + 32'(i));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL uncfg_ready cyc %0d got %b want 0000", k, req_ready); end
      tick();
    end
    cfg_we = 1'b1; cfg_m = 32'd3329; cfg_minv = 8'hFF;
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL cfg_cycle_ready got %b want 0000", req_ready); end
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL first_grant got %b want 0001", req_ready); end
    total++; if (mul_m !== 32'd3329 || mul_minv !== 8'hFF) begin bad++; $display("FAIL cfg_load got %0d/%h want 3329/ff", mul_m, mul_minv); end
    tick();
    req_valid = '0;
    repeat (6) tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    set_op(0, 32'd1353, 32'd17);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got %b want 0001", req_ready); end
    total++; if (mul_a !== 32'd1353 || mul_b !== 32'd17) begin bad++; $display("FAIL single_ops got %0d/%0d want 1353/17", mul_a, mul_b); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_rsp0 got %b want 0000", rsp_valid); end
    tick();
    req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin bad++; $display("FAIL bubble got %0d/%0d want 0/0", mul_a, mul_b); end
      end
      total++;
      if (rsp_valid !== ((k == 4) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL single_rsp c+%0d got %b want %b", k, rsp_valid, (k == 4) ? 4'b0001 : 4'b0000);
      end
      if (k == 4) begin
        total++; if (rsp_s !== 32'd17) begin bad++; $display("FAIL single_s got %0d want 17", rsp_s); end
      end
      tick();
    end
  endtask

  task automatic test_all_four();
    logic [3:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    do_cfg(32'd3329);
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd1353, 32'd10 + 32'(i));
    for (int k = 0; k < 14; k++) begin
      req_valid = (k < 10) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      exp = (k < 10) ? (4'b0001 << (k % 4)) : 4'b0000;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL rr4_grant cyc %0d got %b want %b", k, req_ready, exp); end
      exp = (k >= 4) ? (4'b0001 << ((k - 4) % 4)) : 4'b0000;
      total++; if (rsp_valid !== exp) begin bad++; $display("FAIL rr4_rsp cyc %0d got %b want %b", k, rsp_valid, exp); end
      if (k >= 4) begin
        total++;
        if (rsp_s !== 32'd10 + 32'((k - 4) % 4)) begin
          bad++; $display("FAIL rr4_s cyc %0d got %0d want %0d", k, rsp_s, 10 + (k - 4) % 4);
        end
      end
      tick();
    end
  endtask

  task automatic test_pair();
    logic [3:0] exp;
    set_op(1, 32'd1353, 32'd31);
    set_op(3, 32'd1353, 32'd33);
    for (int k = 0; k <= 10; k++) begin
      req_valid = (k < 6) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      exp = (k < 6) ? ((k % 2 == 0) ? 4'b1000 : 4'b0010) : 4'b0000;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL pair_grant cyc %0d got %b want %b", k, req_ready, exp); end
      exp = (k >= 4 && k < 10) ? (((k - 4) % 2 == 0) ? 4'b1000 : 4'b0010) : 4'b0000;
      total++; if (rsp_valid !== exp) begin bad++; $display("FAIL pair_rsp cyc %0d got %b want %b", k, rsp_valid, exp); end
      if (k >= 4 && k < 10) begin
        total++;
        if (rsp_s !== (((k - 4) % 2 == 0) ? 32'd33 : 32'd31)) begin
          bad++; $display("FAIL pair_s cyc %0d got %0d", k, rsp_s);
        end
      end
      total++; if (idle !== (k >= 9)) begin bad++; $display("FAIL pair_idle cyc %0d got %b want %b", k, idle, k >= 9); end
      tick();
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp;
    for (int k = 0; k < 14; k++) begin
      if (k < 3) begin
        req_valid = 4'b0001; set_op(0, 32'd1353, 32'd21 + 32'(k));
      end else if (k <= 8) begin
        req_valid = 4'b0001; set_op(0, 32'd5569, 32'd100);
      end else begin
        req_valid = 4'b0000;
      end
      cfg_we = (k == 3); cfg_m = 32'd7681; cfg_minv = 8'hFF;
      @(negedge clk);
      exp = (k < 3 || k == 8) ? 4'b0001 : 4'b0000;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL drain_grant cyc %0d got %b want %b", k, req_ready, exp); end
      exp = ((k >= 4 && k <= 6) || k == 12) ? 4'b0001 : 4'b0000;
      total++; if (rsp_valid !== exp) begin bad++; $display("FAIL drain_rsp cyc %0d got %b want %b", k, rsp_valid, exp); end
      if (k >= 4 && k <= 6) begin
        total++;
        if (rsp_s !== 32'd21 + 32'(k - 4)) begin bad++; $display("FAIL drain_old_s cyc %0d got %0d want %0d", k, rsp_s, 21 + k - 4); end
      end
      if (k == 12) begin
        total++; if (rsp_s !== 32'd100) begin bad++; $display("FAIL drain_new_s got %0d want 100", rsp_s); end
      end
      if (k == 7) begin
        total++; if (mul_m !== 32'd3329) begin bad++; $display("FAIL drain_m_copy got %0d want 3329", mul_m); end
      end
      if (k == 8) begin
        total++; if (mul_m !== 32'd7681) begin bad++; $display("FAIL drain_m_new got %0d want 7681", mul_m); end
      end
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd1353, 32'd40 + 32'(i));
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b1111;
      @(negedge clk);
      exp = 4'b0001 << ((k + 1) % 4);
      total++; if (req_ready !== exp) begin bad++; $display("FAIL rmid_grant cyc %0d got %b want %b", k, req_ready, exp); end
      tick();
    end
    req_valid = 4'b0000; rst = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rmid_rsp_in_rst got %b want 0000", rsp_valid); end
    tick();
    rst = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rmid_rsp cyc %0d got %b want 0000", k, rsp_valid); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_ready cyc %0d got %b want 0000", k, req_ready); end
      total++; if (idle !== 1'b0) begin bad++; $display("FAIL rmid_idle cyc %0d got %b want 0", k, idle); end
      if (k == 0) begin
        total++; if (mul_m !== 32'd0) begin bad++; $display("FAIL rmid_m got %0d want 0", mul_m); end
`ifdef MONT_ARB_PERF_EN
        total++; if (perf_issue_cnt !== '0) begin bad++; $display("FAIL rmid_perf_issue got %h want 0", perf_issue_cnt); end
        total++; if (perf_stall_cnt !== 32'd0) begin bad++; $display("FAIL rmid_perf_stall got %0d want 0", perf_stall_cnt); end
`endif
      end
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_uncfg();
    test_single();
    test_all_four();
    test_pair();
    test_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
